// File: rtl/dcache_refill_pkg.sv
// Shared constants and state encoding for the dcache line-refill engine.
package dcache_refill_pkg;

  localparam int LINE_WORDS = 8;
  localparam int INDEX_W    = 7;
  localparam int WORD_W     = 32;
  localparam int LINE_W     = LINE_WORDS * WORD_W;
  localparam int CNT_W      = $clog2(LINE_WORDS);
  localparam int OFFSET_W   = $clog2(LINE_W / 8);

  localparam logic [7:0] ARLEN_LINE   = 8'd7;
  localparam logic [2:0] ARSIZE_4B    = 3'd2;
  localparam logic [1:0] ARBURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY    = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_WR   = 2'd3
  } refill_state_t;

endpackage

// File: rtl/dcache_refill_if.sv
// AXI read address/data channels between the refill engine and the interconnect.
interface dcache_refill_if;
  import dcache_refill_pkg::*;

  logic              arvalid;
  logic              arready;
  logic [WORD_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;

  logic              rvalid;
  logic              rready;
  logic [WORD_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;

  modport master (
    output arvalid, araddr, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rresp, rlast
  );

  modport slave (
    input  arvalid, araddr, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata, rresp, rlast
  );

endinterface

// File: rtl/dcache_line_asm.sv
// Gathers accepted 32-bit beats into a 256-bit line; the beat counter selects the slot.
module dcache_line_asm
  import dcache_refill_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              beat_en,
  input  logic [WORD_W-1:0] beat_data,
  output logic [CNT_W-1:0]  cnt,
  output logic              full,
  output logic [LINE_W-1:0] line
);

  logic [CNT_W-1:0] cnt_reg, cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (clear) begin
      cnt_next = '0;
    end else if (beat_en) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign cnt  = cnt_reg;
  // Asserted in the cycle the final beat is accepted, so the line is complete next cycle.
  assign full = beat_en && (cnt_reg == CNT_W'(LINE_WORDS - 1));

  generate
    for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_slot
      logic [WORD_W-1:0] word_reg;
      logic              slot_we;

      assign slot_we = beat_en && (cnt_reg == CNT_W'(gi));

      always_ff @(posedge clk) begin
        if (slot_we) begin
          word_reg <= beat_data;
        end
      end

      assign line[gi*WORD_W +: WORD_W] = word_reg;
    end
  endgenerate

endmodule

// File: rtl/dcache_refill.sv
// Dcache line-refill engine: one 8-beat AXI INCR burst per miss, critical-word
// forwarding, and a single full-line write into the data bank.
module dcache_refill
  import dcache_refill_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                refill_req,
  input  logic [WORD_W-1:0]   refill_addr,
  output logic                refill_busy,
  output logic                refill_done,
  output logic                refill_err,
  output logic                crit_valid,
  output logic [WORD_W-1:0]   crit_data,
  dcache_refill_if.master     axi,
  output logic                line_wen,
  output logic [LINE_W/8-1:0] line_wstrb,
  output logic [INDEX_W-1:0]  line_windex,
  output logic [LINE_W-1:0]   line_data
);

  refill_state_t     state_reg, state_next;
  logic [WORD_W-1:0] addr_reg, addr_next;
  logic              err_reg, err_next;

  logic              start;
  logic              rready_int;
  logic              beat_en;
  logic              beat_bad;
  logic              line_full;
  logic [CNT_W-1:0]  beat_cnt;
  logic [LINE_W-1:0] line_asm;
  logic              unused_byte_off;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      addr_reg  <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      err_reg   <= err_next;
    end
  end

  assign start      = (state_reg == ST_IDLE) && refill_req;
  assign rready_int = (state_reg == ST_R);
  assign beat_en    = axi.rvalid && rready_int;

  // The burst is always eight beats; rlast must line up with the eighth one.
  assign beat_bad = (axi.rresp != RESP_OKAY) ||
                    (axi.rlast != (beat_cnt == CNT_W'(LINE_WORDS - 1)));

  always_comb begin
    state_next  = state_reg;
    addr_next   = addr_reg;
    err_next    = err_reg;
    axi.arvalid = 1'b0;
    line_wen    = 1'b0;
    line_wstrb  = '0;
    refill_done = 1'b0;
    refill_err  = 1'b0;
    refill_busy = 1'b1;

    case (state_reg)
      ST_IDLE: begin
        refill_busy = 1'b0;
        if (refill_req) begin
          addr_next  = refill_addr;
          err_next   = 1'b0;
          state_next = ST_AR;
        end
      end
      ST_AR: begin
        axi.arvalid = 1'b1;
        if (axi.arready) begin
          state_next = ST_R;
        end
      end
      ST_R: begin
        if (beat_en && beat_bad) begin
          err_next = 1'b1;
        end
        if (line_full) begin
          state_next = ST_WR;
        end
      end
      ST_WR: begin
        line_wen    = 1'b1;
        line_wstrb  = '1;
        refill_done = 1'b1;
        refill_err  = err_reg;
        state_next  = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign axi.araddr  = {addr_reg[WORD_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
  assign axi.arlen   = ARLEN_LINE;
  assign axi.arsize  = ARSIZE_4B;
  assign axi.arburst = ARBURST_INCR;
  assign axi.rready  = rready_int;

  // Critical word is forwarded straight from the R channel, no extra cycle.
  assign crit_valid = beat_en && (beat_cnt == addr_reg[2 +: CNT_W]);
  assign crit_data  = axi.rdata;

  assign line_windex = addr_reg[OFFSET_W +: INDEX_W];
  assign line_data   = line_asm;

  assign unused_byte_off = ^addr_reg[1:0];

  dcache_line_asm u_line_asm (
    .clk       (clk),
    .rst       (rst),
    .clear     (start),
    .beat_en   (beat_en),
    .beat_data (axi.rdata),
    .cnt       (beat_cnt),
    .full      (line_full),
    .line      (line_asm)
  );

endmodule

// File: tb/tb_dcache_refill.sv
// Directed + randomized bench for dcache_refill; the interconnect side and the
// expected line/error/critical word are modelled from the burst contents.
module tb_dcache_refill;
  import dcache_refill_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          refill_req;
  logic [31:0]   refill_addr;
  logic          refill_busy;
  logic          refill_done;
  logic          refill_err;
  logic          crit_valid;
  logic [31:0]   crit_data;
  logic          line_wen;
  logic [31:0]   line_wstrb;
  logic [6:0]    line_windex;
  logic [255:0]  line_data;

  dcache_refill_if axi ();

  dcache_refill dut (
    .clk         (clk),
    .rst         (rst),
    .refill_req  (refill_req),
    .refill_addr (refill_addr),
    .refill_busy (refill_busy),
    .refill_done (refill_done),
    .refill_err  (refill_err),
    .crit_valid  (crit_valid),
    .crit_data   (crit_data),
    .axi         (axi),
    .line_wen    (line_wen),
    .line_wstrb  (line_wstrb),
    .line_windex (line_windex),
    .line_data   (line_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, observed no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_quiet();
    axi.arready = 1'b0;
    axi.rvalid  = 1'b0;
    axi.rdata   = $urandom;
    axi.rresp   = 2'($urandom);
    axi.rlast   = 1'($urandom);
  endtask

  // While busy the controller may wiggle req/addr; the engine must ignore both.
  task automatic busy_noise(input bit noisy);
    refill_req  = noisy;
    refill_addr = $urandom;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      refill_req = 1'b0;
      bus_quiet();
      #1;
      chk("idle_busy", 256'(refill_busy), 256'(0));
      chk("idle_wen", 256'(line_wen), 256'(0));
    end
  endtask

  // Called in an IDLE cycle, 1 time unit after the falling edge.
  task automatic do_refill(input string name, input logic [31:0] addr, input int ar_wait,
                           input int gap_mode, input int bad_beat, input int rlast_beat,
                           input int rst_beat, input bit noisy, input bit seq_beats);
    logic [31:0]  beat_q [8];
    logic [255:0] exp_line;
    logic [31:0]  exp_araddr;
    logic         v;
    logic         exp_crit;
    bit           exp_err;
    int           crit_idx;
    int           k;
    int           stalls;
    int           rcyc;
    int           crit_hits;

    crit_idx   = int'(addr[4:2]);
    exp_araddr = addr & 32'hFFFF_FFE0;
    exp_err    = (bad_beat >= 0 && bad_beat < 8) || (rlast_beat != 7);
    for (int i = 0; i < 8; i++) begin
      beat_q[i] = seq_beats ? 32'h11 * 32'(i + 1) : $urandom;
      exp_line[32*i +: 32] = beat_q[i];
    end

    refill_req  = 1'b1;
    refill_addr = addr;
    bus_quiet();
    #1;
    chk({name, ":req_busy"}, 256'(refill_busy), 256'(0));
    chk({name, ":req_arvalid"}, 256'(axi.arvalid), 256'(0));

    for (int w = 0; w <= ar_wait; w++) begin
      @(negedge clk);
      busy_noise(noisy);
      bus_quiet();
      axi.arready = (w == ar_wait);
      #1;
      chk({name, ":arvalid"}, 256'(axi.arvalid), 256'(1));
      chk({name, ":araddr"}, 256'(axi.araddr), 256'(exp_araddr));
      chk({name, ":arlen"}, 256'(axi.arlen), 256'(7));
      chk({name, ":arsize"}, 256'(axi.arsize), 256'(2));
      chk({name, ":arburst"}, 256'(axi.arburst), 256'(1));
      chk({name, ":ar_rready"}, 256'(axi.rready), 256'(0));
      chk({name, ":ar_busy"}, 256'(refill_busy), 256'(1));
    end

    k = 0;
    stalls = 0;
    rcyc = 0;
    crit_hits = 0;
    while (k < 8) begin
      if (rcyc > 300) begin
        chk({name, ":r_timeout"}, 256'(k), 256'(8));
        break;
      end
      @(negedge clk);
      busy_noise(noisy);
      bus_quiet();
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = (rcyc % 2 == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      axi.rvalid = v;
      if (v) begin
        axi.rdata = beat_q[k];
        axi.rresp = (k == bad_beat) ? 2'b10 : 2'b00;
        axi.rlast = (k == rlast_beat);
      end
      if (v && k == rst_beat) rst = 1'b1;
      exp_crit = v && (k == crit_idx);
      #1;
      chk({name, ":rready"}, 256'(axi.rready), 256'(1));
      chk({name, ":r_arvalid"}, 256'(axi.arvalid), 256'(0));
      chk({name, ":r_wen"}, 256'(line_wen), 256'(0));
      chk({name, ":r_done"}, 256'(refill_done), 256'(0));
      chk({name, ":crit_valid"}, 256'(crit_valid), 256'(exp_crit));
      if (exp_crit) chk({name, ":crit_data"}, 256'(crit_data), 256'(beat_q[k]));
      if (crit_valid === 1'b1) crit_hits++;
      if (v) k++;
      else stalls++;
      rcyc++;

      if (rst === 1'b1) begin
        @(negedge clk);
        rst = 1'b0;
        refill_req = 1'b0;
        bus_quiet();
        #1;
        chk({name, ":rst_busy"}, 256'(refill_busy), 256'(0));
        chk({name, ":rst_rready"}, 256'(axi.rready), 256'(0));
        chk({name, ":rst_wen"}, 256'(line_wen), 256'(0));
        chk({name, ":rst_done"}, 256'(refill_done), 256'(0));
        idle_cycles(9);
        $display("refill %s addr=%08h aborted by reset after %0d beats", name, addr, k);
        return;
      end
    end

    @(negedge clk);
    busy_noise(noisy);
    bus_quiet();
    #1;
    chk({name, ":wen"}, 256'(line_wen), 256'(1));
    chk({name, ":wstrb"}, 256'(line_wstrb), 256'(32'hFFFF_FFFF));
    chk({name, ":windex"}, 256'(line_windex), 256'(addr[11:5]));
    chk({name, ":line"}, line_data, exp_line);
    chk({name, ":done"}, 256'(refill_done), 256'(1));
    chk({name, ":err"}, 256'(refill_err), 256'(exp_err));
    chk({name, ":wr_busy"}, 256'(refill_busy), 256'(1));
    chk({name, ":wr_rready"}, 256'(axi.rready), 256'(0));
    chk({name, ":crit_count"}, 256'(crit_hits), 256'(1));

    @(negedge clk);
    refill_req = 1'b0;
    bus_quiet();
    #1;
    chk({name, ":post_wen"}, 256'(line_wen), 256'(0));
    chk({name, ":post_done"}, 256'(refill_done), 256'(0));
    chk({name, ":post_busy"}, 256'(refill_busy), 256'(0));
    $display("refill %s addr=%08h arwait=%0d stalls=%0d err=%0d crit=%0d", name, addr,
             ar_wait, stalls, exp_err, crit_idx);
  endtask

  initial begin
    int aw;
    int bb;
    int rl;

    rst = 1'b1;
    refill_req = 1'b0;
    refill_addr = 32'h0;
    bus_quiet();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", 256'(refill_busy), 256'(0));
    chk("rst_arvalid", 256'(axi.arvalid), 256'(0));
    chk("rst_rready", 256'(axi.rready), 256'(0));
    chk("rst_wen", 256'(line_wen), 256'(0));
    chk("rst_wstrb", 256'(line_wstrb), 256'(0));
    chk("rst_done", 256'(refill_done), 256'(0));
    chk("rst_err", 256'(refill_err), 256'(0));
    chk("rst_crit", 256'(crit_valid), 256'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;

    do_refill("best", 32'h0000_1234, 0, 0, -1, 7, -1, 1'b0, 1'b1);
    do_refill("b2b_slow", 32'h0000_1234, 4, 1, -1, 7, -1, 1'b1, 1'b1);
    idle_cycles(2);
    do_refill("resp_err", 32'h8000_0F48, 1, 0, 3, 7, -1, 1'b0, 1'b0);
    do_refill("rlast_err", 32'h0001_07FC, 0, 2, -1, 6, -1, 1'b1, 1'b0);
    idle_cycles(1);
    do_refill("rst_mid", 32'h0000_1234, 0, 0, -1, 7, 4, 1'b0, 1'b0);
    do_refill("after_rst", 32'h0000_1234, 2, 0, -1, 7, -1, 1'b0, 1'b1);

    for (int t = 0; t < 12; t++) begin
      aw = int'($urandom_range(0, 5));
      bb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
      rl = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 6)) : 7;
      do_refill($sformatf("rand%0d", t), $urandom, aw, 2, bb, rl, -1,
                1'($urandom), 1'b0);
      if ($urandom_range(0, 1) == 1) idle_cycles(int'($urandom_range(1, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
